lbp_engine: RTL and testbench
=============================

LBP_ENGINE -- requirements
Module: lbp_engine

Interface
REQ-001 Parameter IMG_LOG2, default 7: image is square, N = 2^IMG_LOG2 pixels per side (legal range 2..8).
REQ-002 Parameter DW, default 8: gray pixel width in bits; lbp_data is always 8 bits.
REQ-003 Derived AW = 2*IMG_LOG2; pixel address = (row << IMG_LOG2) + col.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 gray_ready  in  1  source image available; start request.
REQ-007 cmp_mode  in  1  0: neighbour >= center+thr sets bit; 1: neighbour > center+thr sets bit.
REQ-008 thr  in  DW  unsigned comparison offset.
REQ-009 gray_addr  out  AW  read address, registered.
REQ-010 gray_req  out  1  read request.
REQ-011 gray_data  in  DW  mem[gray_addr] valid one cycle after the address is driven with gray_req=1.
REQ-012 lbp_addr  out  AW  write address (center pixel).
REQ-013 lbp_valid  out  1  one-cycle write strobe.
REQ-014 lbp_data  out  8  LBP code.
REQ-015 finish  out  1  registered, sticky completion flag.

Function
REQ-016 FSM states: IDLE, ROWLOAD, COLSHIFT, OUT, DONE.
REQ-017 IDLE: on the edge gray_ready=1 is sampled (E0), latch cmp_mode and thr, set row=1, col=1, enter ROWLOAD; gray_ready, cmp_mode and thr are ignored in every other state.
REQ-018 ROWLOAD: issue 9 addresses on consecutive edges E1..E9 (rows row-1..row+1 × cols 0..2, raster order), gray_req=1; capture each datum one edge later into 3x3 window; last datum captured at E10, then OUT.
REQ-019 COLSHIFT: window shifts left one column; issue 3 addresses (col+1 of rows row-1, row, row+1) on 3 consecutive edges; last datum captured on the 4th edge, then OUT.
REQ-020 gray_req shall be 0 in IDLE, OUT, DONE, and high only while addresses are being issued.
REQ-021 OUT: register lbp_valid=1, lbp_addr=(row<<IMG_LOG2)+col, lbp_data=code for one cycle; lbp_valid=0 in every other cycle.
REQ-022 Code bits: bit0 TL, bit1 T, bit2 TR, bit3 L, bit4 R, bit5 BL, bit6 B, bit7 BR.
REQ-023 Comparison done at DW+1 bits (center+thr never overflows); strictness per latched cmp_mode.
REQ-024 After OUT: if col<N-2, col+1, go COLSHIFT; else if row<N-2, col=1, row+1, go ROWLOAD; else go DONE.
REQ-025 Timing: first lbp_valid registered at E11; within a row, subsequent pulses every 5 cycles; first pixel of each new row 11 cycles after previous pulse.
REQ-026 Border pixels (row or col 0 or N-1) are never written; total writes (N-2)^2.
REQ-027 DONE: finish=1 registered on entry together with the last write's following edge, held until reset; no further reads or writes.

Reset
REQ-028 reset=1 at any time, including mid-fetch, immediately forces: gray_addr=0, gray_req=0, lbp_addr=0, lbp_valid=0, lbp_data=0, finish=0, window=0, row=col=1, state IDLE.
REQ-029 After reset release, operation restarts only on a new gray_ready sample; no partial pixel is ever written.

Verification
REQ-030 Flat image all 50, thr=0, cmp_mode=0 -> every interior write 0xFF; thr=1 -> every write 0x00.
REQ-031 Gradient gray=col, thr=0, cmp_mode=0 -> all writes 0xD6; cmp_mode=1 -> all writes 0x94.
REQ-032 IMG_LOG2=3 random image -> exactly 36 writes, addresses 9..54 interior only, codes match reference model, finish rises after write to address 54.
REQ-033 Cycle check IMG_LOG2=7 -> first lbp_valid at E11, second at E16, first pulse of row 2 11 cycles after write to address 254.
REQ-034 Assert reset during 5th ROWLOAD read of row 3 -> all outputs 0 same cycle, no write for row 3; restart with gray_ready produces a full correct image.
REQ-035 Toggle cmp_mode/thr mid-image -> results unchanged from values latched at start.

Source files
------------

// File: rtl/lbp_engine.sv
// -----------------------------------------------------------------------------
// lbp_engine
//   Computes the 8-bit Local Binary Pattern code of every interior pixel of a
//   square gray image. The image is N x N with N = 2**IMG_LOG2. Pixels are
//   read through a simple synchronous-address memory port, and one code is
//   written per interior pixel.
//
//   Ports
//     clk         single clock, rising edge
//     reset       asynchronous, active-high
//     gray_ready  start request, sampled only in IDLE
//     cmp_mode    0: neighbour >= center+thr, 1: neighbour > center+thr
//                 (latched at start)
//     thr         unsigned comparison offset (latched at start)
//     gray_addr   registered read address, (row << IMG_LOG2) + col
//     gray_req    read request, high only while addresses are issued
//     gray_data   mem[gray_addr], captured on the edge after the address
//     lbp_addr    write address of the center pixel
//     lbp_valid   one-cycle write strobe
//     lbp_data    LBP code: b0 TL, b1 T, b2 TR, b3 L, b4 R, b5 BL, b6 B, b7 BR
//     finish      sticky completion flag, cleared only by reset
// -----------------------------------------------------------------------------
module lbp_engine #(
   parameter  int IMG_LOG2 = 7,
   parameter  int DW       = 8,
   localparam int AW       = 2*IMG_LOG2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          gray_ready,
   input  logic          cmp_mode,
   input  logic [DW-1:0] thr,
   output logic [AW-1:0] gray_addr,
   output logic          gray_req,
   input  logic [DW-1:0] gray_data,
   output logic [AW-1:0] lbp_addr,
   output logic          lbp_valid,
   output logic [7:0]    lbp_data,
   output logic          finish
);

   typedef enum logic [2:0] {S_IDLE, S_ROWLOAD, S_COLSHIFT, S_OUT, S_DONE} state_t;

   // Last interior row/column index (N-2).
   localparam logic [IMG_LOG2-1:0] LAST = IMG_LOG2'((1 << IMG_LOG2) - 2);
   localparam logic [IMG_LOG2-1:0] ONE  = IMG_LOG2'(1);

   state_t                       state_q;
   logic [3:0]                   cnt_q;
   logic [IMG_LOG2-1:0]          row_q, col_q;
   logic                         mode_q;
   logic [DW-1:0]                thr_q;
   logic [2:0][2:0][DW-1:0]      win_q;      // [row][col] of the 3x3 window
   // Window slot that the datum arriving this cycle belongs to.
   logic                         pend_v_q;
   logic [1:0]                   pend_r_q, pend_c_q;

   // ---------------------------------------------------------------------------
   // Fetch offset within the window for the address issued this cycle
   // ---------------------------------------------------------------------------
   logic [1:0]          rofs, cofs;
   logic [IMG_LOG2-1:0] fetch_r, fetch_c;

   always_comb begin
      rofs = 2'd0;
      cofs = 2'd0;
      if (state_q == S_COLSHIFT) begin
         rofs = cnt_q[1:0];
         cofs = 2'd2;
      end else begin
         case (cnt_q)
            4'd0:    begin rofs = 2'd0; cofs = 2'd0; end
            4'd1:    begin rofs = 2'd0; cofs = 2'd1; end
            4'd2:    begin rofs = 2'd0; cofs = 2'd2; end
            4'd3:    begin rofs = 2'd1; cofs = 2'd0; end
            4'd4:    begin rofs = 2'd1; cofs = 2'd1; end
            4'd5:    begin rofs = 2'd1; cofs = 2'd2; end
            4'd6:    begin rofs = 2'd2; cofs = 2'd0; end
            4'd7:    begin rofs = 2'd2; cofs = 2'd1; end
            default: begin rofs = 2'd2; cofs = 2'd2; end
         endcase
      end
   end

   // The window is centred on (row, col), so offset 0 is row-1 / col-1.
   assign fetch_r = row_q + IMG_LOG2'(rofs) - ONE;
   assign fetch_c = col_q + IMG_LOG2'(cofs) - ONE;

   // ---------------------------------------------------------------------------
   // LBP code: compare at DW+1 bits so that center+thr cannot wrap
   // ---------------------------------------------------------------------------
   logic [DW:0]   ref_v;
   logic [DW-1:0] nb [8];
   logic [7:0]    code;

   assign ref_v = {1'b0, win_q[1][1]} + {1'b0, thr_q};

   always_comb begin
      nb[0] = win_q[0][0];
      nb[1] = win_q[0][1];
      nb[2] = win_q[0][2];
      nb[3] = win_q[1][0];
      nb[4] = win_q[1][2];
      nb[5] = win_q[2][0];
      nb[6] = win_q[2][1];
      nb[7] = win_q[2][2];
      code  = 8'd0;
      for (int i = 0; i < 8; i++)
         code[i] = mode_q ? ({1'b0, nb[i]} >  ref_v)
                          : ({1'b0, nb[i]} >= ref_v);
   end

   // ---------------------------------------------------------------------------
   // Control FSM with registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         row_q     <= ONE;
         col_q     <= ONE;
         mode_q    <= 1'b0;
         thr_q     <= '0;
         win_q     <= '0;
         pend_v_q  <= 1'b0;
         pend_r_q  <= 2'd0;
         pend_c_q  <= 2'd0;
         gray_addr <= '0;
         gray_req  <= 1'b0;
         lbp_addr  <= '0;
         lbp_valid <= 1'b0;
         lbp_data  <= 8'd0;
         finish    <= 1'b0;
      end else begin
         lbp_valid <= 1'b0;
         pend_v_q  <= 1'b0;

         // Datum for the address issued on the previous edge.
         if (pend_v_q)
            win_q[pend_r_q][pend_c_q] <= gray_data;

         case (state_q)
            S_IDLE: begin
               if (gray_ready) begin
                  mode_q  <= cmp_mode;
                  thr_q   <= thr;
                  row_q   <= ONE;
                  col_q   <= ONE;
                  cnt_q   <= 4'd0;
                  state_q <= S_ROWLOAD;
               end
            end

            S_ROWLOAD: begin
               if (cnt_q == 4'd9) begin
                  gray_req <= 1'b0;
                  cnt_q    <= 4'd0;
                  state_q  <= S_OUT;
               end else begin
                  gray_req  <= 1'b1;
                  gray_addr <= {fetch_r, fetch_c};
                  pend_v_q  <= 1'b1;
                  pend_r_q  <= rofs;
                  pend_c_q  <= cofs;
                  cnt_q     <= cnt_q + 4'd1;
               end
            end

            S_COLSHIFT: begin
               // Slide left once; the right column refills over the next edges.
               if (cnt_q == 4'd0) begin
                  for (int r = 0; r < 3; r++) begin
                     win_q[r][0] <= win_q[r][1];
                     win_q[r][1] <= win_q[r][2];
                  end
               end
               if (cnt_q == 4'd3) begin
                  gray_req <= 1'b0;
                  cnt_q    <= 4'd0;
                  state_q  <= S_OUT;
               end else begin
                  gray_req  <= 1'b1;
                  gray_addr <= {fetch_r, fetch_c};
                  pend_v_q  <= 1'b1;
                  pend_r_q  <= rofs;
                  pend_c_q  <= cofs;
                  cnt_q     <= cnt_q + 4'd1;
               end
            end

            S_OUT: begin
               lbp_valid <= 1'b1;
               lbp_addr  <= {row_q, col_q};
               lbp_data  <= code;
               if (col_q < LAST) begin
                  col_q   <= col_q + ONE;
                  state_q <= S_COLSHIFT;
               end else if (row_q < LAST) begin
                  col_q   <= ONE;
                  row_q   <= row_q + ONE;
                  state_q <= S_ROWLOAD;
               end else begin
                  state_q <= S_DONE;
               end
            end

            S_DONE: begin
               finish <= 1'b1;
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lbp_engine.sv
// -----------------------------------------------------------------------------
// tb_lbp_engine
//   Two instances: an 8x8 engine for functional checks and a 128x128 engine
//   for the cycle-timing checks. Memories are modelled as combinational reads
//   of the registered address.
// -----------------------------------------------------------------------------
module tb_lbp_engine;

   localparam int SN = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Small instance (IMG_LOG2 = 3)
   logic       rst_s, gr_s, md_s, gq_s, lv_s, fin_s;
   logic [7:0] th_s, gd_s, ld_s;
   logic [5:0] ga_s, la_s;
   logic [7:0] mem8 [64];
   assign gd_s = mem8[ga_s];

   lbp_engine #(.IMG_LOG2(3), .DW(8)) u_small (
      .clk(clk), .reset(rst_s), .gray_ready(gr_s), .cmp_mode(md_s), .thr(th_s),
      .gray_addr(ga_s), .gray_req(gq_s), .gray_data(gd_s),
      .lbp_addr(la_s), .lbp_valid(lv_s), .lbp_data(ld_s), .finish(fin_s));

   // Big instance (IMG_LOG2 = 7)
   logic        rst_b, gr_b, md_b, gq_b, lv_b, fin_b;
   logic [7:0]  th_b, gd_b, ld_b;
   logic [13:0] ga_b, la_b;
   assign gd_b = ga_b[7:0] ^ {2'b00, ga_b[13:8]};

   lbp_engine #(.IMG_LOG2(7), .DW(8)) u_big (
      .clk(clk), .reset(rst_b), .gray_ready(gr_b), .cmp_mode(md_b), .thr(th_b),
      .gray_addr(ga_b), .gray_req(gq_b), .gray_data(gd_b),
      .lbp_addr(la_b), .lbp_valid(lv_b), .lbp_data(ld_b), .finish(fin_b));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] ref_code(input int r, input int c,
                                           input logic m, input logic [7:0] t);
      logic [7:0] cd = 8'd0;
      int k = 0;
      int ctr = int'(mem8[r*SN+c]) + int'(t);
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) begin
               int n = int'(mem8[(r+dr)*SN + (c+dc)]);
               cd[k] = m ? (n > ctr) : (n >= ctr);
               k++;
            end
      return cd;
   endfunction

   task automatic fill_mem(input int pat);
      for (int r = 0; r < SN; r++)
         for (int c = 0; c < SN; c++)
            case (pat)
               0:       mem8[r*SN+c] = 8'd50;
               1:       mem8[r*SN+c] = 8'(c);
               2:       mem8[r*SN+c] = 8'(r);
               default: mem8[r*SN+c] = 8'($urandom_range(0, 255));
            endcase
   endtask

   task automatic reset_small();
      @(negedge clk);
      rst_s = 1'b1; gr_s = 1'b0;
      @(negedge clk);
      rst_s = 1'b0;
   endtask

   // Run one full image on the small engine and check every write.
   task automatic run_image(input bit use_exp, input logic [7:0] expc,
                            input logic mode, input logic [7:0] th,
                            input bit toggle, input string tag);
      int nw = 0, er = 1, ec = 1, extra = 0;
      bit seen_fin = 0;
      @(negedge clk);
      md_s = mode; th_s = th; gr_s = 1'b1;
      for (int cyc = 0; cyc < 2000 && !seen_fin; cyc++) begin
         @(negedge clk);
         if (toggle) begin
            md_s = 1'($urandom); th_s = 8'($urandom);
         end else begin
            gr_s = 1'b0;
         end
         if (lv_s) begin
            chk({tag, " addr"}, 32'(la_s), 32'(er*SN+ec));
            chk({tag, " code"}, 32'(ld_s),
                32'(use_exp ? expc : ref_code(er, ec, mode, th)));
            if (nw == 35) chk({tag, " finish low on last write"}, 32'(fin_s), 32'd0);
            nw++;
            if (ec == SN-2) begin ec = 1; er++; end else ec++;
         end else if (nw == 36) begin
            chk({tag, " finish after last write"}, 32'(fin_s), 32'd1);
            seen_fin = 1;
         end
      end
      chk({tag, " write count"}, 32'(nw), 32'd36);
      chk({tag, " finish seen"}, 32'(seen_fin), 32'd1);
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (lv_s || gq_s) extra++;
      end
      chk({tag, " quiet in done"}, 32'(extra), 32'd0);
      chk({tag, " finish sticky"}, 32'(fin_s), 32'd1);
      gr_s = 1'b0;
   endtask

   typedef struct {
      int         pat;
      logic       mode;
      logic [7:0] th;
      logic [7:0] exp;
   } vec_t;

   vec_t vt [6];

   initial begin
      rst_s = 1'b1; gr_s = 1'b0; md_s = 1'b0; th_s = 8'd0;
      rst_b = 1'b1; gr_b = 1'b0; md_b = 1'b0; th_b = 8'd0;
      for (int i = 0; i < 64; i++) mem8[i] = 8'd0;

      // Reset state
      #12;
      chk("rst gray_addr", 32'(ga_s), 32'd0);
      chk("rst gray_req",  32'(gq_s), 32'd0);
      chk("rst lbp_addr",  32'(la_s), 32'd0);
      chk("rst lbp_valid", 32'(lv_s), 32'd0);
      chk("rst lbp_data",  32'(ld_s), 32'd0);
      chk("rst finish",    32'(fin_s), 32'd0);
      @(negedge clk);
      rst_s = 1'b0; rst_b = 1'b0;

      // Uniform patterns with hand-computed codes
      vt[0] = '{pat: 0, mode: 1'b0, th: 8'd0, exp: 8'hFF};
      vt[1] = '{pat: 0, mode: 1'b0, th: 8'd1, exp: 8'h00};
      vt[2] = '{pat: 0, mode: 1'b1, th: 8'd0, exp: 8'h00};
      vt[3] = '{pat: 1, mode: 1'b0, th: 8'd0, exp: 8'hD6};
      vt[4] = '{pat: 1, mode: 1'b1, th: 8'd0, exp: 8'h94};
      vt[5] = '{pat: 2, mode: 1'b0, th: 8'd0, exp: 8'hF8};
      for (int i = 0; i < 6; i++) begin
         fill_mem(vt[i].pat);
         reset_small();
         run_image(1'b1, vt[i].exp, vt[i].mode, vt[i].th, 1'b0, $sformatf("vec%0d", i));
      end

      // Random image against the reference model
      fill_mem(3);
      reset_small();
      run_image(1'b0, 8'd0, 1'b0, 8'd3, 1'b0, "rand m0");
      reset_small();
      run_image(1'b0, 8'd0, 1'b1, 8'd0, 1'b0, "rand m1");

      // Inputs toggled mid-image; start request held high throughout
      reset_small();
      run_image(1'b0, 8'd0, 1'b0, 8'd2, 1'b1, "toggle");

      // Reset during the 5th read of row 3
      begin
         int cyc = 0, wr = 0;
         fill_mem(3);
         reset_small();
         @(negedge clk);
         md_s = 1'b0; th_s = 8'd0; gr_s = 1'b1;
         @(negedge clk);
         gr_s = 1'b0;
         while (!(lv_s && la_s == 6'd22) && cyc < 500) begin
            @(negedge clk);
            cyc++;
         end
         chk("midrst reached row2 end", 32'(cyc < 500), 32'd1);
         repeat (5) @(posedge clk);
         #1;
         chk("midrst 5th addr", 32'(ga_s), 32'd25);
         chk("midrst req high", 32'(gq_s), 32'd1);
         rst_s = 1'b1;
         #1;
         chk("midrst gray_addr", 32'(ga_s), 32'd0);
         chk("midrst gray_req",  32'(gq_s), 32'd0);
         chk("midrst lbp_addr",  32'(la_s), 32'd0);
         chk("midrst lbp_data",  32'(ld_s), 32'd0);
         chk("midrst lbp_valid", 32'(lv_s), 32'd0);
         repeat (3) @(negedge clk);
         rst_s = 1'b0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lv_s || gq_s) wr++;
         end
         chk("midrst idle after release", 32'(wr), 32'd0);
         run_image(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, "restart");
      end

      // Cycle timing on the 128x128 engine
      begin
         int n = 0, v1 = -1, v2 = -1, p254 = -1, pnext = -1;
         logic [13:0] a1 = '0, anext = '0;
         @(negedge clk);
         gr_b = 1'b1;
         @(posedge clk);          // E0
         #1 gr_b = 1'b0;
         while (pnext < 0 && n < 1500) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) begin
               chk("big E1 req",  32'(gq_b), 32'd1);
               chk("big E1 addr", 32'(ga_b), 32'd0);
            end
            if (n == 9)  chk("big E9 addr", 32'(ga_b), 32'd258);
            if (n == 10) chk("big E10 req", 32'(gq_b), 32'd0);
            if (lv_b) begin
               if (v1 < 0) begin v1 = n; a1 = la_b; end
               else if (v2 < 0) v2 = n;
               if (p254 >= 0 && pnext < 0 && n > p254) begin pnext = n; anext = la_b; end
               if (la_b == 14'd254) p254 = n;
            end
         end
         chk("big first valid edge",  32'(v1), 32'd11);
         chk("big first addr",        32'(a1), 32'd129);
         chk("big second valid edge", 32'(v2), 32'd16);
         chk("big row2 gap",          32'(pnext - p254), 32'd11);
         chk("big row2 addr",         32'(anext), 32'd257);
         @(negedge clk);
         rst_b = 1'b1;
         @(negedge clk);
         chk("big reset finish", 32'(fin_b), 32'd0);
         rst_b = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
